// File: rtl/dp_ram_stream_reader_if.sv
// Bundles the command, RAM read-port and output-stream signals of the stream reader.
// The reader takes the slave view; the command issuer, RAM and consumer side take the master view.
interface dp_ram_stream_reader_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 11
);
   logic                  CmdValid_SI;
   logic                  CmdReady_SO;
   logic [ADDR_WIDTH-1:0] CmdAddr_DI;
   logic [LEN_WIDTH-1:0]  CmdLen_DI;
   logic [ADDR_WIDTH-1:0] RdAddr_DO;
   logic [DATA_WIDTH-1:0] RdData_DI;
   logic                  OutValid_SO;
   logic                  OutReady_SI;
   logic [DATA_WIDTH-1:0] OutData_DO;
   logic                  OutLast_SO;
   logic                  Busy_SO;

   modport slave (
      input  CmdValid_SI, CmdAddr_DI, CmdLen_DI, RdData_DI, OutReady_SI,
      output CmdReady_SO, RdAddr_DO, OutValid_SO, OutData_DO, OutLast_SO, Busy_SO
   );

   modport master (
      output CmdValid_SI, CmdAddr_DI, CmdLen_DI, RdData_DI, OutReady_SI,
      input  CmdReady_SO, RdAddr_DO, OutValid_SO, OutData_DO, OutLast_SO, Busy_SO
   );
endinterface

// File: rtl/dp_ram_stream_reader.sv
// Burst read engine for the dual-port RAM: walks the asynchronous read port sequentially
// and presents the words as a valid/ready stream through a single registered output stage.
module dp_ram_stream_reader #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_DEPTH = 1024,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 11
) (
   input  logic                  Clk_CI,
   input  logic                  Rst_RBI,
   dp_ram_stream_reader_if.slave bus
);
   localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DATA_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(DATA_DEPTH - 1);

   typedef enum logic {IDLE, STREAM} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic                  out_vld_q, out_vld_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_last_q, out_last_d;
   logic                  load;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;
      load       = (state_q == STREAM) && (rem_q != '0) && (!out_vld_q || bus.OutReady_SI);

      // Zero-length commands are accepted but leave the engine idle.
      if ((state_q == IDLE) && bus.CmdValid_SI && (bus.CmdLen_DI != '0)) begin
         addr_d  = ({1'b0, bus.CmdAddr_DI} >= DEPTH_C) ? '0 : bus.CmdAddr_DI;
         rem_d   = bus.CmdLen_DI;
         state_d = STREAM;
      end

      if (load) begin
         out_data_d = bus.RdData_DI;
         out_vld_d  = 1'b1;
         out_last_d = (rem_q == LEN_WIDTH'(1));
         rem_d      = rem_q - LEN_WIDTH'(1);
         addr_d     = (addr_q == LAST_C) ? '0 : addr_q + ADDR_WIDTH'(1);
         if (rem_q == LEN_WIDTH'(1)) begin
            state_d = IDLE;
         end
      end else if (out_vld_q && bus.OutReady_SI) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         out_last_q <= out_last_d;
      end
   end

   assign bus.CmdReady_SO = (state_q == IDLE);
   assign bus.RdAddr_DO   = addr_q;
   assign bus.OutValid_SO = out_vld_q;
   assign bus.OutData_DO  = out_data_q;
   assign bus.OutLast_SO  = out_last_q;
   assign bus.Busy_SO     = (state_q == STREAM) || out_vld_q;
endmodule

// File: tb/tb_dp_ram_stream_reader.sv
// Self-checking bench for dp_ram_stream_reader: directed burst table, hand-written corner
// sequences, and randomized traffic scored against a queue of expected (address, last) beats.
module tb_dp_ram_stream_reader;
   localparam int AW    = 10;
   localparam int DEPTH = 1000;
   localparam int DW    = 32;
   localparam int LW    = 11;
   localparam logic [DW-1:0] BASE = 32'h1000_0000;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   dp_ram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

   dp_ram_stream_reader #(
      .ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
   ) dut (
      .Clk_CI (clk),
      .Rst_RBI(rst_n),
      .bus    (bus)
   );

   logic [DW-1:0] mem [0:(1<<AW)-1];
   assign bus.RdData_DI = mem[bus.RdAddr_DO];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [LW-1:0] len;
      logic [15:0]   pat;
      int            first;
      int            nbeats;
   } vec_t;
   vec_t vecs [8];

   typedef struct {
      int addr;
      bit last;
   } beat_t;
   beat_t expq [$];

   bit            r_pstall = 1'b0;
   logic [DW-1:0] r_pd     = '0;
   logic          r_pl     = 1'b0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int            got = 0;
      int            cyc = 0;
      bit            pstall = 1'b0;
      bit            done = 1'b0;
      bit            rdy;
      logic [DW-1:0] pd = '0;
      logic          pl = 1'b0;
      while (!bus.CmdReady_SO && cyc < 50) begin
         tick();
         cyc++;
      end
      bus.CmdAddr_DI  = v.addr;
      bus.CmdLen_DI   = v.len;
      bus.CmdValid_SI = 1'b1;
      bus.OutReady_SI = v.pat[0];
      tick();
      bus.CmdValid_SI = 1'b0;
      for (cyc = 1; cyc < 120 && !done; cyc++) begin
         if (pstall) begin
            chk($sformatf("v%0d_hold_vld", idx), 64'(bus.OutValid_SO), 64'(1));
            chk($sformatf("v%0d_hold_data", idx), 64'(bus.OutData_DO), 64'(pd));
            chk($sformatf("v%0d_hold_last", idx), 64'(bus.OutLast_SO), 64'(pl));
         end
         if (!bus.Busy_SO) begin
            done = 1'b1;
         end else begin
            rdy = (cyc < 16) ? v.pat[cyc] : 1'b1;
            bus.OutReady_SI = rdy;
            if (bus.OutValid_SO && rdy) begin
               chk($sformatf("v%0d_b%0d_data", idx, got), 64'(bus.OutData_DO),
                   64'(BASE + DW'((v.first + got) % DEPTH)));
               chk($sformatf("v%0d_b%0d_last", idx, got), 64'(bus.OutLast_SO),
                   64'(got == v.nbeats - 1));
               got++;
            end
            pstall = bus.OutValid_SO && !rdy;
            pd     = bus.OutData_DO;
            pl     = bus.OutLast_SO;
            tick();
         end
      end
      chk($sformatf("v%0d_finished", idx), 64'(done), 64'(1));
      chk($sformatf("v%0d_beats", idx), 64'(got), 64'(v.nbeats));
      chk($sformatf("v%0d_cmd_ready", idx), 64'(bus.CmdReady_SO), 64'(1));
   endtask

   task automatic rand_cycle(input bit allow_cmd, input int rdy_pct);
      bit    rdy, cv;
      int    ca, cl, a;
      beat_t b;
      if (r_pstall) begin
         chk("rnd_hold_vld", 64'(bus.OutValid_SO), 64'(1));
         chk("rnd_hold_data", 64'(bus.OutData_DO), 64'(r_pd));
         chk("rnd_hold_last", 64'(bus.OutLast_SO), 64'(r_pl));
      end
      chk("rnd_busy", 64'(bus.Busy_SO), 64'(expq.size() != 0));
      if (expq.size() == 0) begin
         chk("rnd_valid_when_empty", 64'(bus.OutValid_SO), 64'(0));
         chk("rnd_ready_when_empty", 64'(bus.CmdReady_SO), 64'(1));
      end
      rdy = ($urandom_range(0, 99) < rdy_pct);
      cv  = allow_cmd && ($urandom_range(0, 99) < 30);
      ca  = $urandom_range(0, (1 << AW) - 1);
      cl  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 24);
      bus.OutReady_SI = rdy;
      bus.CmdValid_SI = cv;
      bus.CmdAddr_DI  = AW'(ca);
      bus.CmdLen_DI   = LW'(cl);
      if (bus.OutValid_SO && rdy && expq.size() != 0) begin
         b = expq.pop_front();
         chk("rnd_data", 64'(bus.OutData_DO), 64'(mem[b.addr]));
         chk("rnd_last", 64'(bus.OutLast_SO), 64'(b.last));
      end
      if (cv && bus.CmdReady_SO && cl != 0) begin
         a = (ca >= DEPTH) ? 0 : ca;
         for (int k = 0; k < cl; k++) begin
            expq.push_back('{(a + k) % DEPTH, (k == cl - 1)});
         end
      end
      r_pstall = bus.OutValid_SO && !rdy;
      r_pd     = bus.OutData_DO;
      r_pl     = bus.OutLast_SO;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t recov;
      vecs[0] = '{10'd5,    11'd4, 16'hFFFF, 5,   4};
      vecs[1] = '{10'd998,  11'd4, 16'hFFFF, 998, 4};
      vecs[2] = '{10'd1010, 11'd2, 16'hFFFF, 0,   2};
      vecs[3] = '{10'd100,  11'd3, 16'hFFF3, 100, 3};
      vecs[4] = '{10'd50,   11'd0, 16'hFFFF, 0,   0};
      vecs[5] = '{10'd996,  11'd6, 16'hAAAB, 996, 6};
      vecs[6] = '{10'd1023, 11'd3, 16'h5555, 0,   3};
      vecs[7] = '{10'd10,   11'd1, 16'hFFFF, 10,  1};
      for (int i = 0; i < (1 << AW); i++) mem[i] = BASE + DW'(i);
      bus.CmdValid_SI = 1'b0;
      bus.CmdAddr_DI  = '0;
      bus.CmdLen_DI   = '0;
      bus.OutReady_SI = 1'b0;

      // Asynchronous reset before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("rst_cmd_ready", 64'(bus.CmdReady_SO), 64'(1));
      chk("rst_out_valid", 64'(bus.OutValid_SO), 64'(0));
      chk("rst_out_data", 64'(bus.OutData_DO), 64'(0));
      chk("rst_out_last", 64'(bus.OutLast_SO), 64'(0));
      chk("rst_rd_addr", 64'(bus.RdAddr_DO), 64'(0));
      chk("rst_busy", 64'(bus.Busy_SO), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single burst: latency and last-beat timing
      bus.CmdAddr_DI  = 10'd5;
      bus.CmdLen_DI   = 11'd4;
      bus.CmdValid_SI = 1'b1;
      bus.OutReady_SI = 1'b1;
      tick();
      bus.CmdValid_SI = 1'b0;
      chk("lat_cmd_ready", 64'(bus.CmdReady_SO), 64'(0));
      chk("lat_valid", 64'(bus.OutValid_SO), 64'(0));
      chk("lat_rd_addr", 64'(bus.RdAddr_DO), 64'(5));
      chk("lat_busy", 64'(bus.Busy_SO), 64'(1));
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("lat_b%0d_valid", k), 64'(bus.OutValid_SO), 64'(1));
         chk($sformatf("lat_b%0d_data", k), 64'(bus.OutData_DO), 64'(BASE + DW'(5 + k)));
         chk($sformatf("lat_b%0d_last", k), 64'(bus.OutLast_SO), 64'(k == 3));
         chk($sformatf("lat_b%0d_cmd_ready", k), 64'(bus.CmdReady_SO), 64'(k == 3));
      end
      tick();
      chk("lat_end_valid", 64'(bus.OutValid_SO), 64'(0));
      chk("lat_end_busy", 64'(bus.Busy_SO), 64'(0));

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Back-to-back bursts with one bubble
      bus.OutReady_SI = 1'b1;
      bus.CmdAddr_DI  = 10'd10;
      bus.CmdLen_DI   = 11'd2;
      bus.CmdValid_SI = 1'b1;
      tick();
      bus.CmdAddr_DI = 10'd20;
      chk("b2b_ready_busy", 64'(bus.CmdReady_SO), 64'(0));
      tick();
      chk("b2b_b0_valid", 64'(bus.OutValid_SO), 64'(1));
      chk("b2b_b0_data", 64'(bus.OutData_DO), 64'(BASE + 10));
      tick();
      chk("b2b_b1_data", 64'(bus.OutData_DO), 64'(BASE + 11));
      chk("b2b_b1_last", 64'(bus.OutLast_SO), 64'(1));
      chk("b2b_b1_cmd_ready", 64'(bus.CmdReady_SO), 64'(1));
      tick();
      bus.CmdValid_SI = 1'b0;
      chk("b2b_bubble_valid", 64'(bus.OutValid_SO), 64'(0));
      chk("b2b_bubble_ready", 64'(bus.CmdReady_SO), 64'(0));
      tick();
      chk("b2b_b2_valid", 64'(bus.OutValid_SO), 64'(1));
      chk("b2b_b2_data", 64'(bus.OutData_DO), 64'(BASE + 20));
      chk("b2b_b2_last", 64'(bus.OutLast_SO), 64'(0));
      tick();
      chk("b2b_b3_data", 64'(bus.OutData_DO), 64'(BASE + 21));
      chk("b2b_b3_last", 64'(bus.OutLast_SO), 64'(1));
      tick();
      chk("b2b_end_valid", 64'(bus.OutValid_SO), 64'(0));

      // Reset in the middle of a burst
      bus.CmdAddr_DI  = 10'd200;
      bus.CmdLen_DI   = 11'd8;
      bus.CmdValid_SI = 1'b1;
      tick();
      bus.CmdValid_SI = 1'b0;
      tick();
      tick();
      tick();
      chk("mid_third_data", 64'(bus.OutData_DO), 64'(BASE + 202));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(bus.OutValid_SO), 64'(0));
      chk("mid_rst_cmd_ready", 64'(bus.CmdReady_SO), 64'(1));
      chk("mid_rst_busy", 64'(bus.Busy_SO), 64'(0));
      chk("mid_rst_rd_addr", 64'(bus.RdAddr_DO), 64'(0));
      chk("mid_rst_last", 64'(bus.OutLast_SO), 64'(0));
      #2 rst_n = 1'b1;
      tick();
      recov = '{10'd300, 11'd3, 16'hFFFF, 300, 3};
      run_vec(recov, 8);

      // Write to the address being loaded on the same edge
      bus.OutReady_SI = 1'b0;
      bus.CmdAddr_DI  = 10'd7;
      bus.CmdLen_DI   = 11'd1;
      bus.CmdValid_SI = 1'b1;
      tick();
      bus.CmdValid_SI = 1'b0;
      @(posedge clk);
      mem[7] <= 32'h0000_DEAD;
      #1;
      chk("rdw_valid", 64'(bus.OutValid_SO), 64'(1));
      chk("rdw_old_data", 64'(bus.OutData_DO), 64'(BASE + 7));
      chk("rdw_last", 64'(bus.OutLast_SO), 64'(1));
      bus.OutReady_SI = 1'b1;
      tick();
      chk("rdw_drained", 64'(bus.OutValid_SO), 64'(0));
      bus.CmdValid_SI = 1'b1;
      tick();
      bus.CmdValid_SI = 1'b0;
      tick();
      chk("rdw_new_valid", 64'(bus.OutValid_SO), 64'(1));
      chk("rdw_new_data", 64'(bus.OutData_DO), 64'(32'h0000_DEAD));
      tick();

      // Randomized traffic against the beat queue
      for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
      r_pstall = 1'b0;
      for (int c = 0; c < 1500; c++) rand_cycle(1'b1, 70);
      for (int c = 0; c < 400 && (expq.size() != 0 || bus.Busy_SO); c++) rand_cycle(1'b0, 100);
      chk("rnd_drained", 64'(expq.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
